result_collector: RTL

// Downstream stage of the bfm DUT. Captures one res_o result per valid cycle, packs four

---
 rtl/result_collector.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/result_collector.sv
// ---------------------------------------------------------------------------
// result_collector
//
// Downstream stage of the bfm DUT. Accepts one result per valid/ready
// handshake, packs four results into each word (earliest result in the
// lowest lane), buffers the words in a first-word-fall-through FIFO and
// streams each batch of NUM results out on a valid/ready/last interface.
// batch_done_o pulses for one cycle once the final word of a batch has left.
//
// Ports
//   clk_i         in   clock, all logic on posedge
//   reset_i       in   synchronous active-high reset
//   res_valid_i   in   res_i holds a result this cycle
//   res_i         in   result from bfm res_o
//   res_ready_o   out  collector accepts res_i this cycle
//   out_valid_o   out  out_data_o / out_last_o are valid
//   out_data_o    out  packed word, earliest result in bits [RES_WIDTH-1:0]
//   out_last_o    out  marks the final word of a batch
//   out_ready_i   in   consumer takes the head word this cycle
//   batch_done_o  out  one-cycle pulse after the last word of a batch is taken
//   res_count_o   out  results accepted in the current batch
// ---------------------------------------------------------------------------
module result_collector #(
    parameter int NUM        = 100,
    parameter int RES_WIDTH  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       res_valid_i,
    input  logic [RES_WIDTH-1:0]       res_i,
    output logic                       res_ready_o,
    output logic                       out_valid_o,
    output logic [4*RES_WIDTH-1:0]     out_data_o,
    output logic                       out_last_o,
    input  logic                       out_ready_i,
    output logic                       batch_done_o,
    output logic [$clog2(NUM+1)-1:0]   res_count_o
);

    localparam int WW = 4 * RES_WIDTH;
    localparam int CW = $clog2(NUM + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 2;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;

    logic [1:0]         lane_idx_r;
    logic [WW-1:0]      lanes_r;
    logic [WW-1:0]      packed_s;
    logic [CW-1:0]      count_r;

    // One-cycle staging register between the packer and the FIFO, so a word
    // completed at edge N is written at edge N+1.
    logic               stg_valid_r;
    logic [WW-1:0]      stg_data_r;
    logic               stg_last_r;

    logic [WW:0]        mem_r [FIFO_DEPTH];
    logic [AW:0]        wr_ptr_r;
    logic [AW:0]        rd_ptr_r;
    logic [AW:0]        fill_s;
    logic [OW-1:0]      occupancy_s;
    logic               fifo_empty_s;
    logic               full_eff_s;
    logic [WW:0]        head_s;

    logic               last_res_s;
    logic               push_on_accept_s;
    logic               res_ready_s;
    logic               accept_s;
    logic               pop_s;

    // FIFO occupancy, handshake qualifiers and head entry
    always_comb begin
        fill_s           = wr_ptr_r - rd_ptr_r;
        // The staged word is already committed to the FIFO, so it counts
        // against the free space when deciding whether to accept.
        occupancy_s      = OW'(fill_s) + OW'(stg_valid_r);
        fifo_empty_s     = (fill_s == {(AW+1){1'b0}});
        full_eff_s       = (occupancy_s >= OW'(FIFO_DEPTH));
        head_s           = mem_r[rd_ptr_r[AW-1:0]];
        last_res_s       = (count_r == CW'(NUM - 1));
        push_on_accept_s = (lane_idx_r == 2'd3) || last_res_s;
        res_ready_s      = (state_r == ST_COLLECT) && !(push_on_accept_s && full_eff_s);
        accept_s         = res_valid_i && res_ready_s;
        pop_s            = !fifo_empty_s && out_ready_i;
    end

    // Partial word with the incoming result merged into the current lane
    always_comb begin
        packed_s = lanes_r;
        for (int j = 0; j < 4; j++) begin
            if (lane_idx_r == 2'(j)) begin
                packed_s[j*RES_WIDTH +: RES_WIDTH] = res_i;
            end else begin
                packed_s[j*RES_WIDTH +: RES_WIDTH] = lanes_r[j*RES_WIDTH +: RES_WIDTH];
            end
        end
    end

    // Batch FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_COLLECT: begin
                if (accept_s && last_res_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_COLLECT;
                end
            end
            ST_DRAIN: begin
                if (pop_s && head_s[WW]) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_COLLECT;
            end
            default: begin
                state_nxt_s = ST_COLLECT;
            end
        endcase
    end

    // Batch FSM state register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= ST_COLLECT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Per-batch result counter; holds at NUM through DRAIN and DONE
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_r <= {CW{1'b0}};
        end else if (state_r == ST_DONE) begin
            count_r <= {CW{1'b0}};
        end else if (accept_s) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // Packer lanes and the staging register feeding the FIFO
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lane_idx_r  <= 2'd0;
            lanes_r     <= {WW{1'b0}};
            stg_valid_r <= 1'b0;
            stg_data_r  <= {WW{1'b0}};
            stg_last_r  <= 1'b0;
        end else begin
            stg_valid_r <= accept_s && push_on_accept_s;
            if (accept_s && push_on_accept_s) begin
                // Lanes above the current index are still zero, which gives
                // the zero fill of a short final word for free.
                stg_data_r <= packed_s;
                stg_last_r <= last_res_s;
                lanes_r    <= {WW{1'b0}};
                lane_idx_r <= 2'd0;
            end else if (accept_s) begin
                lanes_r    <= packed_s;
                lane_idx_r <= lane_idx_r + 2'd1;
            end else begin
                lanes_r    <= lanes_r;
                lane_idx_r <= lane_idx_r;
            end
        end
    end

    // FIFO pointers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (stg_valid_r) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // FIFO storage; contents are masked at the output while empty, so no reset
    always_ff @(posedge clk_i) begin
        if (stg_valid_r) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {stg_last_r, stg_data_r};
        end
    end

    // Output drive, all derived from registered state
    always_comb begin
        res_ready_o  = res_ready_s;
        out_valid_o  = !fifo_empty_s;
        if (fifo_empty_s) begin
            out_data_o = {WW{1'b0}};
            out_last_o = 1'b0;
        end else begin
            out_data_o = head_s[WW-1:0];
            out_last_o = head_s[WW];
        end
        batch_done_o = (state_r == ST_DONE);
        res_count_o  = count_r;
    end

endmodule
